and4_bist_ctrl: RTL and testbench
=================================

# and4_bist_ctrl

Built-in self-test sequencer for the team's 4-input AND unit (`mixedfourand`, inputs a, b, c, d, output f). On `start` it drives all 16 input combinations into the unit in ascending order and waits a programmable settle time after each. It then samples `f`, compares it against the ideal AND of the vector, and reports pass/fail, an error count and the first failing vector. It sits between the unit under test and a test-mode controller. It replaces hand-written stimulus sequences with a self-checking hardware run.

## Interface

Parameters:
- `SETTLE`, default 2: wait cycles between applying a vector and sampling `f`. Legal range 0..15.
- `CNT_W`, default 5: width of `err_cnt`. Must be at least 5.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: level, sampled only in IDLE; begins a run.
- `abort` in 1: synchronous; terminates a run in progress.
- `uut_a`, `uut_b`, `uut_c`, `uut_d` out 1 each: the current vector, MSB first (vec[3]..vec[0]); registered.
- `uut_f` in 1: response from the unit under test.
- `busy` out 1: high while a run is in progress.
- `done` out 1: one-cycle pulse at the end of a completed run.
- `pass` out 1: 1 when the last completed run had zero mismatches.
- `err_cnt` out CNT_W: number of mismatches, saturating.
- `first_fail_vec` out 4: vector of the first mismatch in the run.
- `first_fail_valid` out 1: high once at least one mismatch has been recorded.

## Operation

States:
- IDLE: `busy`=0. If `start`=1, go to APPLY. On entry to APPLY: vec←0, `err_cnt`←0, `first_fail_valid`←0, `first_fail_vec`←0, `pass`←0.
- APPLY: one cycle with vec driven. Go to WAIT if SETTLE>0, otherwise go to SAMPLE.
- WAIT: hold for exactly SETTLE cycles using an internal counter, then go to SAMPLE.
- SAMPLE: one cycle.
  - Expected value is `exp = (vec == 4'hF)`.
  - If `uut_f != exp`: increment `err_cnt`, saturating at 2^CNT_W−1.
  - If this is the first mismatch, latch `first_fail_vec`←vec and set `first_fail_valid`←1.
  - If vec==15, go to DONE. Otherwise vec←vec+1 and go to APPLY.
- DONE: `done`=1 for one cycle. `pass`←(`err_cnt`==0). Go to IDLE.

Rules:
- `busy` is 1 in APPLY, WAIT and SAMPLE; 0 in IDLE and DONE.
- `start` is ignored outside IDLE, including during DONE. A `start` held high across DONE relaunches a run from IDLE on the following edge.
- `abort` in APPLY, WAIT or SAMPLE: next edge goes to IDLE and sets vec←0.
  - No `done` pulse.
  - `pass` stays 0.
  - `err_cnt` and `first_fail_*` keep their partial values until the next `start`.
- `abort` in IDLE or DONE has no effect. `abort` takes priority over the SAMPLE transition in the same cycle.
- Vector-to-port mapping: vec[3]→`uut_a`, vec[2]→`uut_b`, vec[1]→`uut_c`, vec[0]→`uut_d`.
- Results (`pass`, `err_cnt`, `first_fail_*`) hold indefinitely in IDLE.

## Timing

- Reset (`rst_n`=0, asynchronous): state=IDLE and every output is 0, including vec, `busy`, `done`, `pass`, `err_cnt`, `first_fail_vec` and `first_fail_valid`.
  - Reset mid-run takes effect immediately, with no completion.
  - Deassertion is taken synchronously at the next edge.
- `start` sampled high at edge k:
  - `busy`=1 from after edge k; vector 0 is on the ports after edge k.
  - Each vector occupies SETTLE+2 cycles.
  - Vector n is sampled in the cycle after edge k+(n+1)(SETTLE+2)−1.
  - `done`=1 in the cycle after edge k+16(SETTLE+2), and `pass` is valid from that cycle.
  - State returns to IDLE after edge k+16(SETTLE+2)+1.
- With the default SETTLE=2: 64 cycles from start to `done`.
- Minimum start-to-start spacing is 16(SETTLE+2)+2 cycles.
- `uut_f` is expected to be stable by the SAMPLE cycle. The controller adds no synchroniser.

## Test plan

- Correct AND unit connected, SETTLE=2, `start` pulsed at edge k → `done` in the cycle after edge k+64; `pass`=1, `err_cnt`=0, `first_fail_valid`=0.
- `uut_f` tied to 0 (stuck-at-0) → `err_cnt`=1, `first_fail_vec`=4'hF, `pass`=0.
- `uut_f` tied to 1 (stuck-at-1) → `err_cnt`=15, `first_fail_vec`=4'h0, `pass`=0.
- SETTLE=0, correct unit → `done` after edge k+32. Ports step through 0..15, each held for 2 cycles.
- `abort` asserted while vec=5 → `busy`=0 after the next edge, vec=0, no `done` pulse, `pass`=0. A second `start` is ignored during the run, then a run started from IDLE completes normally.
- `rst_n` pulled low mid-run at vec=9 → all outputs 0 immediately. After release, a run started with `start` passes.

Source files
------------

// File: rtl/and4_bist_ctrl.sv
// BIST sequencer for a 4-input AND unit: walks all 16 vectors, checks f, reports results.
// Each vector takes SETTLE+2 cycles (apply, settle, sample); start-to-done is 16*(SETTLE+2) cycles.
module and4_bist_ctrl #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             uut_a,
    output logic             uut_b,
    output logic             uut_c,
    output logic             uut_d,
    input  logic             uut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0]       WAIT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [CNT_W-1:0] ERR_MAX   = '1;

    state_t             state_q, state_d;
    logic [3:0]         vec_q, vec_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [3:0]         ffv_q, ffv_d;
    logic               ffvld_q, ffvld_d;
    logic               pass_q, pass_d;
    logic               mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= 4'd0;
            wcnt_q  <= 4'd0;
            err_q   <= '0;
            ffv_q   <= 4'd0;
            ffvld_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvld_q <= ffvld_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        wcnt_d   = wcnt_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffvld_d  = ffvld_q;
        pass_d   = pass_q;
        mismatch = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_APPLY;
                    vec_d   = 4'd0;
                    err_d   = '0;
                    ffv_d   = 4'd0;
                    ffvld_d = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                wcnt_d = 4'd0;
                if (abort) begin
                    state_d = S_IDLE;
                    vec_d   = 4'd0;
                end else if (SETTLE > 0) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    vec_d   = 4'd0;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    vec_d   = 4'd0;
                end else begin
                    mismatch = (uut_f != (vec_q == 4'hF));
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        if (!ffvld_q) begin
                            ffv_d   = vec_q;
                            ffvld_d = 1'b1;
                        end
                    end
                    // pass must already be valid in the DONE cycle, so it uses the final count
                    if (vec_q == 4'hF) begin
                        state_d = S_DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = S_APPLY;
                        vec_d   = vec_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign uut_a            = vec_q[3];
    assign uut_b            = vec_q[2];
    assign uut_c            = vec_q[1];
    assign uut_d            = vec_q[0];
    assign busy             = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
    assign done             = (state_q == S_DONE);
    assign pass             = pass_q;
    assign err_cnt          = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvld_q;

endmodule

// File: tb/tb_and4_bist_ctrl.sv
// Bench for and4_bist_ctrl: SETTLE=2 and SETTLE=0 instances against a behavioural AND unit with stuck-at modes.
module tb_and4_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start2, abort2, start0, abort0;
    logic       a2, b2, c2, d2, f2, busy2, done2, pass2, ffvld2;
    logic       a0, b0, c0, d0, f0, busy0, done0, pass0, ffvld0;
    logic [4:0] err2, err0;
    logic [3:0] ffv2, ffv0;
    int         mode2, mode0;   // 0 = good AND, 1 = stuck-at-0, 2 = stuck-at-1

    always_comb f2 = (mode2 == 1) ? 1'b0 : (mode2 == 2) ? 1'b1 : (a2 & b2 & c2 & d2);
    always_comb f0 = (mode0 == 1) ? 1'b0 : (mode0 == 2) ? 1'b1 : (a0 & b0 & c0 & d0);

    and4_bist_ctrl #(.SETTLE(2), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .uut_a(a2), .uut_b(b2), .uut_c(c2), .uut_d(d2), .uut_f(f2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_fail_vec(ffv2), .first_fail_valid(ffvld2)
    );

    and4_bist_ctrl #(.SETTLE(0), .CNT_W(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .uut_a(a0), .uut_b(b0), .uut_c(c0), .uut_d(d0), .uut_f(f0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffvld0)
    );

    typedef struct {
        logic       busy;
        logic [3:0] vec;
    } step_t;

    typedef struct {
        logic [4:0] err;
        logic [3:0] ffv;
        logic       ffvld;
        logic       pass;
    } res_t;

    step_t exp_q[$];
    step_t obs_q[$];
    res_t  res_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    done_idx;
    int    done_cnt;
    logic  pass_at_done;

    // Pulses start on one instance and records busy/vector/done for max_cyc cycles after the start edge.
    task automatic run_collect(input int sel, input int max_cyc);
        step_t s;
        logic  dn;
        obs_q.delete();
        done_idx     = -1;
        done_cnt     = 0;
        pass_at_done = 1'b0;
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start2 = 1'b1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            start0 = 1'b0;
            start2 = 1'b0;
            if (sel == 0) begin
                s.busy = busy0; s.vec = {a0, b0, c0, d0}; dn = done0;
            end else begin
                s.busy = busy2; s.vec = {a2, b2, c2, d2}; dn = done2;
            end
            obs_q.push_back(s);
            if (dn) begin
                done_cnt++;
                if (done_idx < 0) begin
                    done_idx     = i;
                    pass_at_done = (sel == 0) ? pass0 : pass2;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
        mode2 = 0; mode0 = 0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({a2, b2, c2, d2, busy2, done2, pass2, err2, ffv2, ffvld2} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_s2: got vec=%b busy=%b done=%b pass=%b err=%0d ffv=%h ffvld=%b, want all 0",
                     {a2, b2, c2, d2}, busy2, done2, pass2, err2, ffv2, ffvld2);
        end
        n_vec++;
        if ({a0, b0, c0, d0, busy0, done0, pass0, err0, ffv0, ffvld0} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_s0: got vec=%b busy=%b done=%b pass=%b err=%0d, want all 0",
                     {a0, b0, c0, d0}, busy0, done0, pass0, err0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_s2();
        step_t e, o;
        res_t  r;
        mode2 = 0;
        for (int i = 1; i <= 67; i++) begin
            e.busy = (i <= 64);
            e.vec  = 4'((i - 1) / 4);
            exp_q.push_back(e);
        end
        res_q.push_back('{err: 5'd0, ffv: 4'h0, ffvld: 1'b0, pass: 1'b1});
        run_collect(2, 67);
        for (int i = 0; i < 67; i++) begin
            e = exp_q.pop_front();
            o = obs_q[i];
            n_vec++;
            if (o.busy !== e.busy || (e.busy && o.vec !== e.vec)) begin
                n_bad++;
                $display("FAIL good_s2_step%0d: got busy=%b vec=%h, want busy=%b vec=%h",
                         i + 1, o.busy, o.vec, e.busy, e.vec);
            end
        end
        n_vec++;
        if (done_idx != 65 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL good_s2_done: got cycle %0d count %0d, want cycle 65 count 1", done_idx, done_cnt);
        end
        r = res_q.pop_front();
        n_vec++;
        if (pass_at_done !== r.pass || err2 !== r.err || ffvld2 !== r.ffvld || pass2 !== r.pass) begin
            n_bad++;
            $display("FAIL good_s2_result: got pass@done=%b pass=%b err=%0d ffvld=%b, want pass=%b err=%0d ffvld=%b",
                     pass_at_done, pass2, err2, ffvld2, r.pass, r.err, r.ffvld);
        end
    endtask

    task automatic test_stuck(input int mode);
        res_t r;
        mode2 = mode;
        if (mode == 1) res_q.push_back('{err: 5'd1, ffv: 4'hF, ffvld: 1'b1, pass: 1'b0});
        else           res_q.push_back('{err: 5'd15, ffv: 4'h0, ffvld: 1'b1, pass: 1'b0});
        run_collect(2, 72);
        r = res_q.pop_front();
        n_vec++;
        if (done_idx != 65 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL stuck%0d_done: got cycle %0d count %0d, want cycle 65 count 1", mode, done_idx, done_cnt);
        end
        n_vec++;
        if (err2 !== r.err || ffv2 !== r.ffv || ffvld2 !== r.ffvld || pass2 !== r.pass || pass_at_done !== r.pass) begin
            n_bad++;
            $display("FAIL stuck%0d_result: got err=%0d ffv=%h ffvld=%b pass=%b, want err=%0d ffv=%h ffvld=%b pass=%b",
                     mode, err2, ffv2, ffvld2, pass2, r.err, r.ffv, r.ffvld, r.pass);
        end
    endtask

    task automatic test_settle0();
        step_t e, o;
        mode0 = 0;
        for (int i = 1; i <= 35; i++) begin
            e.busy = (i <= 32);
            e.vec  = 4'((i - 1) / 2);
            exp_q.push_back(e);
        end
        run_collect(0, 35);
        for (int i = 0; i < 35; i++) begin
            e = exp_q.pop_front();
            o = obs_q[i];
            n_vec++;
            if (o.busy !== e.busy || (e.busy && o.vec !== e.vec)) begin
                n_bad++;
                $display("FAIL settle0_step%0d: got busy=%b vec=%h, want busy=%b vec=%h",
                         i + 1, o.busy, o.vec, e.busy, e.vec);
            end
        end
        n_vec++;
        if (done_idx != 33 || done_cnt != 1 || pass_at_done !== 1'b1 || err0 !== 5'd0) begin
            n_bad++;
            $display("FAIL settle0_done: got cycle %0d count %0d pass=%b err=%0d, want cycle 33 count 1 pass=1 err=0",
                     done_idx, done_cnt, pass_at_done, err0);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        int cnt = 0;
        mode0 = 0;
        @(negedge clk);
        start0 = 1'b1;
        for (int i = 1; i <= 72; i++) begin
            @(negedge clk);
            if (i == 68) start0 = 1'b0;
            if (done0) begin
                cnt++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        n_vec++;
        if (first != 33 || second != 67 || cnt != 2) begin
            n_bad++;
            $display("FAIL back_to_back: got done at %0d and %0d (count %0d), want 33 and 67 (count 2)",
                     first, second, cnt);
        end
    endtask

    task automatic test_abort();
        int   waited = 0;
        int   dn     = 0;
        mode2 = 2;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        while ({a2, b2, c2, d2} != 4'd5 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (waited >= 100) begin
            n_bad++;
            $display("FAIL abort_reach_vec5: got vec=%h after %0d cycles, want 5", {a2, b2, c2, d2}, waited);
        end
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        n_vec++;
        if (busy2 !== 1'b0 || {a2, b2, c2, d2} !== 4'd0 || pass2 !== 1'b0 || done2 !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_state: got busy=%b vec=%h pass=%b done=%b, want 0 0 0 0",
                     busy2, {a2, b2, c2, d2}, pass2, done2);
        end
        n_vec++;
        if (err2 !== 5'd5 || ffv2 !== 4'h0 || ffvld2 !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_partial: got err=%0d ffv=%h ffvld=%b, want err=5 ffv=0 ffvld=1", err2, ffv2, ffvld2);
        end
        repeat (70) begin
            @(negedge clk);
            if (done2) dn++;
        end
        n_vec++;
        if (dn != 0 || busy2 !== 1'b0 || err2 !== 5'd5) begin
            n_bad++;
            $display("FAIL abort_quiet: got %0d done pulses busy=%b err=%0d, want 0 pulses busy=0 err=5", dn, busy2, err2);
        end
    endtask

    task automatic test_start_ignored();
        int first = -1;
        int cnt = 0;
        mode2 = 0;
        @(negedge clk);
        start2 = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            start2 = (i == 10 || i == 11 || i == 40);
            if (done2) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        start2 = 1'b0;
        n_vec++;
        if (first != 65 || cnt != 1 || pass2 !== 1'b1 || err2 !== 5'd0) begin
            n_bad++;
            $display("FAIL start_ignored: got done at %0d count %0d pass=%b err=%0d, want 65 count 1 pass=1 err=0",
                     first, cnt, pass2, err2);
        end
    endtask

    task automatic test_reset_midrun();
        int waited = 0;
        mode2 = 2;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        while ({a2, b2, c2, d2} != 4'd9 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (waited >= 100 || err2 == 5'd0) begin
            n_bad++;
            $display("FAIL rst_reach_vec9: got vec=%h err=%0d after %0d cycles, want vec 9 with errors",
                     {a2, b2, c2, d2}, err2, waited);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a2, b2, c2, d2, busy2, done2, pass2, err2, ffv2, ffvld2} !== 18'd0) begin
            n_bad++;
            $display("FAIL rst_midrun: got vec=%b busy=%b pass=%b err=%0d ffv=%h ffvld=%b, want all 0",
                     {a2, b2, c2, d2}, busy2, pass2, err2, ffv2, ffvld2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode2 = 0;
        run_collect(2, 67);
        n_vec++;
        if (done_idx != 65 || done_cnt != 1 || pass_at_done !== 1'b1 || err2 !== 5'd0 || ffvld2 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_rerun: got done at %0d count %0d pass=%b err=%0d ffvld=%b, want 65 1 1 0 0",
                     done_idx, done_cnt, pass_at_done, err2, ffvld2);
        end
    endtask

    initial begin
        test_reset();
        test_good_s2();
        test_stuck(1);
        test_stuck(2);
        test_settle0();
        test_back_to_back();
        test_abort();
        test_start_ignored();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
